// File: rtl/tanh_lut_server.sv
// tanh_lut_server: responder for the GELU tanh lookup.
// A magnitude table is streamed in by the host (LOAD). After that, lookups are
// served with a fixed one-cycle latency (RUN). The NaN, saturated and linear
// regions are computed directly, so only the curved middle band is stored.
module tanh_lut_server #(
  parameter logic [11:0] BASE_ADDR = 12'h4E8,
  parameter logic [11:0] SAT_ADDR  = 12'h8A0,
  parameter int          DEPTH     = int'(SAT_ADDR) - int'(BASE_ADDR),
  parameter int          SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [11:0]          req_addr,
  input  logic                 req_sign,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [15:0]          ld_data,
  input  logic                 reload,
  output logic                 table_ready,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [SAT_CNT_W-1:0] SAT_ONE  = SAT_CNT_W'(1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [SAT_CNT_W-1:0]   sat_cnt_q, sat_cnt_d;

  // Table storage: magnitude only, never reset.
  logic [14:0]            mem [DEPTH];
  logic [14:0]            rd_q;

  // Response registers. The stored word and the arithmetic result are kept
  // separately so the RAM read stays a plain synchronous read.
  logic                   rsp_valid_q;
  logic                   use_tbl_q;
  logic                   sign_q;
  logic [15:0]            arith_q;

  logic                   ld_hs_s;
  logic                   req_hs_s;
  logic                   is_nan_s;
  logic                   is_sat_s;
  logic                   is_lin_s;
  logic                   use_tbl_s;
  logic [PTR_W-1:0]       tbl_idx_s;
  logic [15:0]            arith_s;
  logic                   ld_unused_s;

  // Bit 15 of a load word carries no meaning for the magnitude table.
  assign ld_unused_s = ld_data[15];

  assign ld_ready    = (state_q == ST_LOAD);
  assign req_ready   = (state_q == ST_RUN);
  assign table_ready = (state_q == ST_RUN);
  assign ld_hs_s     = ld_valid & ld_ready;
  assign req_hs_s    = req_valid & req_ready;

  // Region decode: NaN beats saturation; Inf (0xF80) falls into saturation.
  assign is_nan_s  = (req_addr[11:7] == 5'h1F) && (req_addr[6:0] != 7'd0);
  assign is_sat_s  = (req_addr >= SAT_ADDR);
  assign is_lin_s  = (req_addr < BASE_ADDR);
  assign use_tbl_s = !is_nan_s && !is_sat_s && !is_lin_s;
  assign tbl_idx_s = PTR_W'(req_addr - BASE_ADDR);

  // Arithmetic (non-table) response value for the current request.
  always_comb begin
    arith_s = 16'h0000;
    if (is_nan_s) begin
      arith_s = 16'h7E00;
    end else if (is_sat_s) begin
      arith_s = {req_sign, 15'h3C00};
    end else begin
      arith_s = {req_sign, req_addr, 3'b000};
    end
  end

  // Next-state logic: load pointer walk, LOAD->RUN on final word, reload override.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (reload) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
    end else if (ld_hs_s) begin
      if (ptr_q == LAST_PTR) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + PTR_ONE;
      end
    end else begin
      state_d = state_q;
      ptr_d   = ptr_q;
    end
  end

  // Saturation-hit counter: cleared by reload, sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (reload) begin
      sat_cnt_d = '0;
    end else if (req_hs_s && is_sat_s && !is_nan_s && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + SAT_ONE;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      ptr_q     <= '0;
      sat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // Single-port table: writes only in LOAD, reads only in RUN.
  always_ff @(posedge clk) begin
    if (ld_hs_s) begin
      mem[ptr_q] <= ld_data[14:0];
    end
    if (req_hs_s && use_tbl_s) begin
      rd_q <= mem[tbl_idx_s];
    end
  end

  // Response pipeline stage; holds its value when no request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      use_tbl_q   <= 1'b0;
      sign_q      <= 1'b0;
      arith_q     <= 16'h0000;
    end else begin
      rsp_valid_q <= req_hs_s;
      if (req_hs_s) begin
        use_tbl_q <= use_tbl_s;
        sign_q    <= req_sign;
        arith_q   <= arith_s;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = use_tbl_q ? {sign_q, rd_q} : arith_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_tanh_lut_server.sv
// Self-checking bench for tanh_lut_server: randomized traffic against a
// behavioural model of the lookup rules, plus the directed boundary cases.
module tb_tanh_lut_server;

  localparam int DEPTH = 952;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = 12'h000;
  logic        req_sign = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [15:0] ld_data = 16'h0000;
  logic        reload = 1'b0;
  logic        table_ready;
  logic [15:0] sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [14:0] m_tbl [DEPTH];
  bit          m_run = 1'b0;
  int          m_ptr = 0;
  int          m_sat = 0;
  bit          m_rv  = 1'b0;
  logic [15:0] m_rd  = 16'h0000;

  tanh_lut_server dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_sign    (req_sign),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .reload      (reload),
    .table_ready (table_ready),
    .sat_cnt     (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected tanh response from the lookup rules.
  function automatic logic [15:0] ref_rsp(input logic [11:0] a, input logic s);
    int idx;
    if (a > 12'hF80) return 16'h7E00;
    if (a >= 12'h8A0) return {s, 15'h3C00};
    if (a < 12'h4E8) return {s, a, 3'b000};
    idx = int'(a) - 32'h4E8;
    return {s, m_tbl[idx]};
  endfunction

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 12'($urandom_range(0, 4095));
      1: return 12'($urandom_range(32'h4E0, 32'h4EF));
      2: return 12'($urandom_range(32'h898, 32'h8A7));
      3: return 12'($urandom_range(32'hF7C, 32'hFFF));
      default: return 12'($urandom_range(32'h4E8, 32'h89F));
    endcase
  endfunction

  // Advance one clock: update the model from the applied inputs, then compare.
  task automatic tick(input string tag);
    bit acc;
    acc = req_valid && m_run;
    if (acc) begin
      m_rv = 1'b1;
      m_rd = ref_rsp(req_addr, req_sign);
    end else begin
      m_rv = 1'b0;
    end
    if (reload) m_sat = 0;
    else if (acc && req_addr >= 12'h8A0 && req_addr <= 12'hF80 && m_sat < 65535) m_sat++;
    if (!m_run && ld_valid) begin
      m_tbl[m_ptr] = ld_data[14:0];
      if (m_ptr == DEPTH - 1) begin
        m_ptr = 0;
        m_run = 1'b1;
      end else begin
        m_ptr++;
      end
    end
    if (reload) begin
      m_run = 1'b0;
      m_ptr = 0;
    end
    @(posedge clk);
    #1;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(m_rv));
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(m_rd));
    check({tag, "_sat_cnt"}, 32'(sat_cnt), m_sat);
    check({tag, "_table_ready"}, 32'(table_ready), 32'(m_run));
    check({tag, "_req_ready"}, 32'(req_ready), 32'(m_run));
    check({tag, "_ld_ready"}, 32'(ld_ready), 32'(!m_run));
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    ld_valid  = 1'b0;
    reload    = 1'b0;
    rst_n     = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);
      check("rst_table_ready", 32'(table_ready), 32'h0);
      check("rst_sat_cnt", 32'(sat_cnt), 32'h0);
      @(posedge clk);
      #1;
    end
    m_run = 1'b0;
    m_ptr = 0;
    m_sat = 0;
    m_rv  = 1'b0;
    m_rd  = 16'h0000;
    rst_n = 1'b1;
  endtask

  // Stream load words until stop_at words are in (or the table completes).
  task automatic load_words(input bit use_pattern, input int stop_at, input string tag);
    int budget;
    budget = 20000;
    while (!m_run && m_ptr < stop_at && budget > 0) begin
      ld_valid  = 1'($urandom_range(0, 1));
      ld_data   = use_pattern ? (16'h8000 | 16'(m_ptr)) : 16'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = rand_addr();
      req_sign  = 1'($urandom_range(0, 1));
      tick(tag);
      budget--;
    end
    ld_valid  = 1'b0;
    req_valid = 1'b0;
    if (budget == 0) check({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic dir_req(input logic [11:0] a, input logic s, input logic [15:0] exp, input string tag);
    req_valid = 1'b1;
    req_addr  = a;
    req_sign  = s;
    tick(tag);
    check({tag, "_lit"}, 32'(rsp_data), 32'(exp));
  endtask

  task automatic random_run(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = rand_addr();
      req_sign  = 1'($urandom_range(0, 1));
      ld_valid  = 1'($urandom_range(0, 1));
      ld_data   = 16'($urandom);
      tick(tag);
    end
    req_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  initial begin
    do_reset();

    // Full pattern load, requests during LOAD must be ignored.
    load_words(1'b1, DEPTH + 1, "load1");
    check("load1_done", 32'(table_ready), 32'h1);

    // Directed lookups, back-to-back.
    dir_req(12'h4E8, 1'b0, 16'h0000, "base");
    dir_req(12'h89F, 1'b1, 16'h83B7, "last");
    dir_req(12'h4E7, 1'b1, 16'hA738, "lin_top");
    dir_req(12'h8A0, 1'b0, 16'h3C00, "sat_first");
    dir_req(12'hF80, 1'b1, 16'hBC00, "inf");
    dir_req(12'hF81, 1'b0, 16'h7E00, "nan");
    req_valid = 1'b0;
    tick("idle");
    check("idle_hold", 32'(rsp_data), 32'h7E00);
    check("sat_two", 32'(sat_cnt), 32'h2);

    // Reload together with an accepted request.
    req_valid = 1'b1;
    req_addr  = 12'h500;
    req_sign  = 1'b0;
    reload    = 1'b1;
    tick("reload");
    check("reload_rsp_lit", 32'(rsp_data), 32'h0018);
    check("reload_trdy", 32'(table_ready), 32'h0);
    check("reload_rrdy", 32'(req_ready), 32'h0);
    check("reload_sat", 32'(sat_cnt), 32'h0);
    reload    = 1'b0;
    req_valid = 1'b0;

    // Partial load interrupted by reset, then a full fresh load.
    load_words(1'b0, 100, "part");
    check("part_count", m_ptr, 100);
    do_reset();
    load_words(1'b0, DEPTH + 1, "load2");
    check("load2_done", 32'(table_ready), 32'h1);

    random_run(1500, "rand");

    // Saturation counter must stick at all-ones.
    for (int k = 0; k < 70000; k++) begin
      req_valid = 1'b1;
      req_addr  = 12'($urandom_range(32'h8A0, 32'hF80));
      req_sign  = 1'($urandom_range(0, 1));
      tick("satrun");
    end
    req_valid = 1'b0;
    check("sat_stick", 32'(sat_cnt), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
